// File: rtl/store_buffer_unit.sv
// MIPS-style SB/SH/SW store buffer: address/lane generation feeding a DEPTH-entry FIFO toward data memory.
// Optional MISALIGN_TRAP_EN: misaligned stores are dropped and flagged instead of being pushed.
module store_buffer_unit #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    input  logic [31:0]       read_data1,
    input  logic [31:0]       read_data2,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              misalign,
    output logic [ADDR_W-1:0] misalign_addr,
    output logic [CNT_W-1:0]  count,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [5:0] OP_SB = 6'h28;
    localparam logic [5:0] OP_SH = 6'h29;
    localparam logic [5:0] OP_SW = 6'h2B;

    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [31:0]       wdata_q [DEPTH];
    logic [3:0]        be_q    [DEPTH];

    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count_next;

    logic [5:0]        opcode;
    logic [15:0]       imm16;
    logic [31:0]       ea;
    logic [ADDR_W-1:0] ea_a;
    logic [ADDR_W-1:0] push_addr;
    logic [31:0]       push_wdata;
    logic [3:0]        push_be;
    logic              is_store;
    logic              accept, push, pop;
    logic              unused_bits;

    assign opcode    = instruction[31:26];
    assign imm16     = instruction[15:0];
    assign ea        = read_data1 + {{16{imm16[15]}}, imm16};
    assign ea_a      = ea[ADDR_W-1:0];
    assign push_addr = {ea_a[ADDR_W-1:2], 2'b00};
    assign unused_bits = ^{instruction[25:16], ea};

    assign in_ready  = reset && (count != CNT_W'(DEPTH));
    assign accept    = in_valid && in_ready;
    assign mem_valid = !empty;
    assign pop       = mem_valid && mem_ready;

    always_comb begin
        is_store   = 1'b0;
        push_be    = '0;
        push_wdata = '0;
        case (opcode)
            OP_SB: begin
                is_store   = 1'b1;
                push_be    = 4'b0001 << ea[1:0];
                push_wdata = {4{read_data2[7:0]}};
            end
            OP_SH: begin
                is_store   = 1'b1;
                push_be    = ea[1] ? 4'b1100 : 4'b0011;
                push_wdata = {2{read_data2[15:0]}};
            end
            OP_SW: begin
                is_store   = 1'b1;
                push_be    = 4'b1111;
                push_wdata = read_data2;
            end
            default: ;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    logic trap;

    assign misaligned = ((opcode == OP_SH) && ea[0]) ||
                        ((opcode == OP_SW) && (ea[1:0] != 2'b00));
    assign trap       = accept && is_store && misaligned;
    assign push       = accept && is_store && !misaligned;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign      <= 1'b0;
            misalign_addr <= '0;
        end else begin
            misalign <= trap;
            if (trap)
                misalign_addr <= ea_a;
        end
    end
`else
    assign push          = accept && is_store;
    assign misalign      = 1'b0;
    assign misalign_addr = '0;
`endif

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            empty <= (count_next == '0);
        end
    end

    // Payload storage carries no reset; validity is tracked solely by count/empty.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr]  <= push_addr;
            wdata_q[wr_ptr] <= push_wdata;
            be_q[wr_ptr]    <= push_be;
        end
    end

    assign mem_addr  = empty ? '0 : addr_q[rd_ptr];
    assign mem_wdata = empty ? '0 : wdata_q[rd_ptr];
    assign mem_be    = empty ? '0 : be_q[rd_ptr];

endmodule
